// File: rtl/mac_cluster_param.sv
// Multiply-accumulate cluster with runtime lane fusion into 2^k-lane groups,
// valid/ready flow control on both sides, signed/unsigned and saturation.
module mac_cluster_param #(
    parameter  int LANES     = 4,
    parameter  int MIN_WIDTH = 8,
    parameter  int ACC_WIDTH = 32,
    parameter  int SATURATE  = 0,
    localparam int MB        = $clog2(LANES) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*MIN_WIDTH-1:0]     a,
    input  logic [LANES*MIN_WIDTH-1:0]     b,
    input  logic [MB-1:0]                  cfg_mode,
    input  logic                           cfg_acc,
    input  logic                           cfg_signed,
    input  logic                           acc_clr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*ACC_WIDTH-1:0]     out_data,
    output logic [LANES-1:0]               overflow
);

    localparam int W  = MIN_WIDTH;
    localparam int A  = ACC_WIDTH;
    localparam int L2 = $clog2(LANES);
    localparam int LA = LANES * A;
    localparam int NM = L2 + 1;

    logic [NM*LA-1:0]    prod_all;
    logic [NM*LA-1:0]    nxt_all;
    logic [NM*LANES-1:0] ovf_all;

    logic [MB-1:0]    mode_c;
    logic [LA-1:0]    prod_d;
    logic [LA-1:0]    prod_q;
    logic [LA-1:0]    acc_d;
    logic [LA-1:0]    acc_q;
    logic [LANES-1:0] ovf_d;
    logic [LANES-1:0] ovf_q;
    logic [MB-1:0]    mode_q;
    logic             accen_q;
    logic             sgn_q;
    logic             s1_valid_q;
    logic             out_valid_q;
    logic             adv1;
    logic             adv2;
    logic             take;

    assign mode_c   = (cfg_mode > MB'(L2)) ? MB'(L2) : cfg_mode;
    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1 && rst && !acc_clr;
    assign take     = in_valid && in_ready;

    // One datapath per fusion mode; the active mode is muxed below.
    for (genvar k = 0; k < NM; k++) begin : g_mode
        localparam int G  = 1 << k;
        localparam int NG = LANES / G;
        localparam int GW = G * W;
        localparam int GA = G * A;
        localparam int PW = 2 * GW;

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic [PW-1:0] opa;
            logic [PW-1:0] opb;
            logic [PW-1:0] prod;
            logic [GA-1:0] pext;
            logic [GA-1:0] accv;
            logic [GA-1:0] pv;
            logic [GA-1:0] smax;
            logic [GA-1:0] res;
            logic [GA:0]   sum;
            logic          ov;
            logic [G-1:0]  ob;

            always_comb begin
                opa  = {{GW{cfg_signed & a[g*GW+GW-1]}}, a[g*GW +: GW]};
                opb  = {{GW{cfg_signed & b[g*GW+GW-1]}}, b[g*GW +: GW]};
                prod = opa * opb;
                pext = {GA{cfg_signed & prod[PW-1]}};
                pext[PW-1:0] = prod;
            end

            assign prod_all[k*LA + g*GA +: GA] = pext;

            always_comb begin
                accv = acc_q[g*GA +: GA];
                pv   = prod_q[g*GA +: GA];
                sum  = {1'b0, accv} + {1'b0, pv};
                if (sgn_q) begin
                    ov = (accv[GA-1] == pv[GA-1]) && (sum[GA-1] != accv[GA-1]);
                end else begin
                    ov = sum[GA];
                end
                ov   = ov && accen_q;
                smax = '1;
                if (sgn_q) begin
                    smax[GA-1] = 1'b0;
                end
                if (!accen_q) begin
                    res = pv;
                end else if (ov && (SATURATE != 0)) begin
                    res = (sgn_q && accv[GA-1]) ? ~smax : smax;
                end else begin
                    res = sum[GA-1:0];
                end
                // Sticky flag lives only at the group base lane.
                ob    = '0;
                ob[0] = ovf_q[g*G] | ov;
            end

            assign nxt_all[k*LA + g*GA +: GA]      = res;
            assign ovf_all[k*LANES + g*G +: G]     = ob;
        end
    end

    always_comb begin
        prod_d = prod_all[LA-1:0];
        acc_d  = nxt_all[LA-1:0];
        ovf_d  = ovf_all[LANES-1:0];
        for (int k = 1; k < NM; k++) begin
            if (mode_c == MB'(k)) begin
                prod_d = prod_all[k*LA +: LA];
            end
            if (mode_q == MB'(k)) begin
                acc_d = nxt_all[k*LA +: LA];
                ovf_d = ovf_all[k*LANES +: LANES];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            mode_q      <= '0;
            accen_q     <= 1'b0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= '0;
        end else if (acc_clr) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= take;
                if (take) begin
                    prod_q  <= prod_d;
                    mode_q  <= mode_c;
                    accen_q <= cfg_acc;
                    sgn_q   <= cfg_signed;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_cluster_param.sv
// Scoreboard bench for mac_cluster_param (4 lanes, 8-bit operands,
// 32-bit accumulators, saturation on) with a wide-integer reference model.
module tb_mac_cluster_param;

    localparam bit SAT = 1'b1;

    typedef logic signed [263:0] big_t;
    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [2:0]   cfg_mode;
    logic         cfg_acc;
    logic         cfg_signed;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   overflow;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    logic [127:0] m_acc = '0;
    logic [3:0]   m_ovf = '0;
    bit done;

    mac_cluster_param #(
        .LANES(4), .MIN_WIDTH(8), .ACC_WIDTH(32), .SATURATE(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .cfg_mode(cfg_mode), .cfg_acc(cfg_acc), .cfg_signed(cfg_signed),
        .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endfunction

    function automatic big_t fld(input logic [127:0] v, input int lsb, input int n, input bit sg);
        big_t r;
        r = '0;
        for (int j = 0; j < n; j++) r[j] = v[lsb+j];
        if (sg && v[lsb+n-1]) r = r - (big_t'(1) <<< n);
        return r;
    endfunction

    // Groups are treated as plain integers; overflow is a range test.
    function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                  input logic [2:0] md, input bit ac, input bit sg,
                                  output logic [127:0] ed, output logic [3:0] eo);
        int k, gs, gw, ga;
        big_t pa, pb, s, hi, lo, one;
        logic [127:0] na;
        logic [3:0] no;
        bit ov;
        k = (md > 3'd2) ? 2 : int'(md);
        gs = 1 << k;
        gw = 8 * gs;
        ga = 32 * gs;
        one = 1;
        na = '0;
        no = '0;
        for (int g = 0; g < 4 / gs; g++) begin
            pa = fld({96'b0, av}, g*gw, gw, sg);
            pb = fld({96'b0, bv}, g*gw, gw, sg);
            s = pa * pb;
            if (ac) s = s + fld(m_acc, g*ga, ga, sg);
            hi = sg ? (one <<< (ga-1)) - one : (one <<< ga) - one;
            lo = sg ? -(one <<< (ga-1)) : big_t'(0);
            ov = (s > hi) || (s < lo);
            if (ov && SAT) s = (s > hi) ? hi : lo;
            for (int j = 0; j < ga; j++) na[g*ga+j] = s[j];
            no[g*gs] = m_ovf[g*gs] | ov;
        end
        m_acc = na;
        m_ovf = no;
        ed = na;
        eo = no;
    endfunction

    function automatic logic [31:0] rnd_ops();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 4))
                0: v[i*8 +: 8] = 8'h00;
                1: v[i*8 +: 8] = 8'hFF;
                2: v[i*8 +: 8] = 8'h80;
                3: v[i*8 +: 8] = 8'h7F;
                default: v[i*8 +: 8] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic send(input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] md, input bit ac, input bit sg,
                        input bit hand, input logic [127:0] hd, input logic [3:0] ho);
        logic [127:0] ed;
        logic [3:0] eo;
        exp_t e;
        int n;
        a = av; b = bv; cfg_mode = md; cfg_acc = ac; cfg_signed = sg;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) break;
        end
        if (!in_ready) begin
            check("send_timeout", 128'(0), 128'(1));
            in_valid = 1'b0;
            return;
        end
        model(av, bv, md, ac, sg, ed, eo);
        e.d = hand ? hd : ed;
        e.o = hand ? ho : eo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        a = rnd_ops(); b = rnd_ops(); cfg_mode = 3'd0; cfg_acc = 1'b1;
        in_valid = 1'b1;
        acc_clr = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        m_acc = '0;
        m_ovf = '0;
        @(negedge clk);
        check("clr_valid", 128'(out_valid), 128'(0));
        check("clr_data", out_data, 128'(0));
        check("clr_ovf", 128'(overflow), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", out_data, 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        exp_q.delete();
        m_acc = '0;
        m_ovf = '0;
        rst = 1'b1;
    endtask

    initial begin
        logic [127:0] pd;
        logic [3:0] po;
        bit ps;
        exp_t e;
        ps = 1'b0;
        pd = '0;
        po = '0;
        forever begin
            @(negedge clk);
            if (ps && rst) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_data", out_data, pd);
                check("stall_ovf", 128'(overflow), 128'(po));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_data, 128'(0) - 128'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_ovf", 128'(overflow), 128'(e.o));
                end
            end
            ps = rst && !acc_clr && out_valid && !out_ready;
            pd = out_data;
            po = overflow;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        cfg_mode = '0; cfg_acc = 1'b0; cfg_signed = 1'b0;
        acc_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 128'(out_valid), 128'(0));
        check("reset_data", out_data, 128'(0));
        check("reset_ovf", 128'(overflow), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 1'b1,
             128'h0000FE01_0000FE01_0000FE01_0000FE01, 4'h0);
        @(negedge clk);
        check("lat_s1", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("lat_s2", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1;

        send(32'hFFFFFFFF, 32'h00020002, 3'd1, 1'b0, 1'b1, 1'b1,
             128'hFFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFE, 4'h0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 1'b0, 1'b0, 1'b1,
             128'h00000000_00000000_FFFFFFFE_00000001, 4'h0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 1'b1, 1'b0, 1'b1,
             128'h00000000_00000001_FFFFFFFC_00000002, 4'h0);

        do_clr();
        send(32'hFFFFFFFF, 32'h80000000, 3'd2, 1'b0, 1'b0, 1'b1,
             128'h00000000_00000000_7FFFFFFF_80000000, 4'h0);
        send(32'h01017F80, 32'hFF017F7F, 3'd0, 1'b1, 1'b1, 1'b1,
             128'hFFFFFFFF_00000001_7FFFFFFF_80000000, 4'b0011);

        do_clr();
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 1'b0, 1'b0, 1'b1,
             128'h00000000_00000000_FFFFFFFE_00000001, 4'h0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 1'b1,
             128'h0000FE01_0000FE01_FFFFFFFF_0000FE02, 4'b0010);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 1'b1,
             128'h0001FC02_0001FC02_FFFFFFFF_0001FC03, 4'b0010);
        send(32'h0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b1,
             128'h0001FC02_0001FC02_FFFFFFFF_0001FC03, 4'b0010);
        send(32'h0, 32'h0, 3'd1, 1'b1, 1'b0, 1'b1,
             128'h0001FC02_0001FC02_FFFFFFFF_0001FC03, 4'b0000);

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(rnd_ops(), rnd_ops(), 3'($urandom_range(0, 2)), 1'b1,
                         1'($urandom_range(0, 1)), 1'b0, '0, '0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 128'(in_ready), 128'(0));
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join

        send(rnd_ops(), rnd_ops(), 3'd1, 1'b1, 1'b0, 1'b0, '0, '0);
        send(rnd_ops(), rnd_ops(), 3'd2, 1'b1, 1'b1, 1'b0, '0, '0);
        do_clr();
        send(32'h03030303, 32'h03030303, 3'd0, 1'b1, 1'b0, 1'b1,
             128'h00000009_00000009_00000009_00000009, 4'h0);

        send(rnd_ops(), rnd_ops(), 3'd0, 1'b1, 1'b1, 1'b0, '0, '0);
        send(rnd_ops(), rnd_ops(), 3'd2, 1'b1, 1'b0, 1'b0, '0, '0);
        do_rst();
        send(32'h03030303, 32'h03030303, 3'd0, 1'b1, 1'b0, 1'b1,
             128'h00000009_00000009_00000009_00000009, 4'h0);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 39) == 0) do_clr();
                    send(rnd_ops(), rnd_ops(), 3'($urandom_range(0, 7)),
                         $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         1'b0, '0, '0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
